// File: rtl/plot_shadow_fb.sv
`default_nettype none
// ============================================================================
//  Module   : plot_shadow_fb
//  Purpose  : Shadow copy of the 160x120 3-bit VGA framebuffer, written by
//             the same pixel-plot strobes as the adapter, with a square
//             region query that counts pixels matching a given colour.
//  Revision : 1.0  initial release
// ============================================================================
module plot_shadow_fb #(
    parameter int         XSCREEN = 160,
    parameter int         YSCREEN = 120,
    parameter int         QDIM    = 10,
    parameter logic [2:0] BG      = 3'b000
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [7:0] x,
    input  logic [6:0] y,
    input  logic [2:0] colour,
    input  logic       plot,
    output logic       busy,
    input  logic       q_start,
    input  logic [7:0] q_x,
    input  logic [6:0] q_y,
    input  logic [2:0] q_colour,
    output logic       q_done,
    output logic       q_hit,
    output logic [6:0] q_count
);

    localparam int c_NPIX   = XSCREEN * YSCREEN;
    localparam int c_ADDR_W = $clog2(c_NPIX);
    localparam int c_CW     = $clog2(QDIM);
    localparam int c_CNT_W  = 7;

    typedef enum logic [1:0] {
        S_CLEAR = 2'd0,
        S_IDLE  = 2'd1,
        S_QUERY = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t                r_state;
    logic [c_ADDR_W-1:0]   r_clr_addr;
    logic                  r_busy;
    logic                  r_q_done;
    logic                  r_q_hit;
    logic [c_CNT_W-1:0]    r_q_count;
    logic [c_CNT_W-1:0]    r_acc;
    logic [7:0]            r_qx;
    logic [6:0]            r_qy;
    logic [2:0]            r_qc;
    logic [c_CW-1:0]       r_xc;
    logic [c_CW-1:0]       r_yc;
    logic                  r_issuing;
    logic                  r_v1;
    logic                  r_inr1;
    logic                  r_v2;
    logic                  r_match;

    logic [2:0]            r_mem [0:c_NPIX-1];
    logic [2:0]            r_rdata;

    logic                  w_plot_in;
    logic [c_ADDR_W-1:0]   w_paddr;
    logic [8:0]            w_qx_sum;
    logic [7:0]            w_qy_sum;
    logic                  w_q_inr;
    logic [c_ADDR_W-1:0]   w_qaddr;
    logic [c_ADDR_W-1:0]   w_raddr;
    logic                  w_we;
    logic [c_ADDR_W-1:0]   w_waddr;
    logic [2:0]            w_wdata;

    // Plot address; out-of-screen plots never reach the memory.
    assign w_plot_in = plot && (32'(x) < XSCREEN) && (32'(y) < YSCREEN);
    assign w_paddr   = c_ADDR_W'(y) * c_ADDR_W'(XSCREEN) + c_ADDR_W'(x);

    // Scan coordinates are summed one bit wider so the edge clip never wraps.
    assign w_qx_sum = {1'b0, r_qx} + 9'(r_xc);
    assign w_qy_sum = {1'b0, r_qy} + 8'(r_yc);
    assign w_q_inr  = (32'(w_qx_sum) < XSCREEN) && (32'(w_qy_sum) < YSCREEN);
    assign w_qaddr  = c_ADDR_W'(w_qy_sum) * c_ADDR_W'(XSCREEN) + c_ADDR_W'(w_qx_sum);
    assign w_raddr  = w_q_inr ? w_qaddr : '0;

    // Write-port mux: the clear sweep owns the port, otherwise plots write.
    always_comb begin
        w_we    = 1'b0;
        w_waddr = r_clr_addr;
        w_wdata = BG;
        if (r_state == S_CLEAR) begin
            w_we = 1'b1;
        end else if (w_plot_in) begin
            w_we    = 1'b1;
            w_waddr = w_paddr;
            w_wdata = colour;
        end
    end

    // Single write / single synchronous read; the read sees the old data on a collision.
    always_ff @(posedge Clock) begin
        if (w_we) begin
            r_mem[w_waddr] <= w_wdata;
        end
        r_rdata <= r_mem[w_raddr];
    end

    // Control FSM: clear sweep, query scan with a two-stage compare pipe, result hold.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state    <= S_CLEAR;
            r_clr_addr <= '0;
            r_busy     <= 1'b1;
            r_q_done   <= 1'b0;
            r_q_hit    <= 1'b0;
            r_q_count  <= '0;
            r_acc      <= '0;
            r_qx       <= '0;
            r_qy       <= '0;
            r_qc       <= '0;
            r_xc       <= '0;
            r_yc       <= '0;
            r_issuing  <= 1'b0;
            r_v1       <= 1'b0;
            r_inr1     <= 1'b0;
            r_v2       <= 1'b0;
            r_match    <= 1'b0;
        end else begin
            r_q_done <= 1'b0;
            r_v1     <= (r_state == S_QUERY) && r_issuing;
            r_inr1   <= w_q_inr;
            r_v2     <= r_v1;
            r_match  <= r_v1 && r_inr1 && (r_rdata == r_qc);

            case (r_state)
                S_CLEAR: begin
                    if (r_clr_addr == c_ADDR_W'(c_NPIX - 1)) begin
                        r_state <= S_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_clr_addr <= r_clr_addr + 1'b1;
                    end
                end
                S_IDLE: begin
                    if (q_start) begin
                        r_qx      <= q_x;
                        r_qy      <= q_y;
                        r_qc      <= q_colour;
                        r_acc     <= '0;
                        r_q_count <= '0;
                        r_q_hit   <= 1'b0;
                        r_xc      <= '0;
                        r_yc      <= '0;
                        r_issuing <= 1'b1;
                        r_busy    <= 1'b1;
                        r_state   <= S_QUERY;
                    end
                end
                S_QUERY: begin
                    if (r_issuing) begin
                        if (r_xc == c_CW'(QDIM - 1)) begin
                            r_xc <= '0;
                            if (r_yc == c_CW'(QDIM - 1)) begin
                                r_issuing <= 1'b0;
                            end else begin
                                r_yc <= r_yc + 1'b1;
                            end
                        end else begin
                            r_xc <= r_xc + 1'b1;
                        end
                    end
                    if (r_v2) begin
                        r_acc <= r_acc + c_CNT_W'(r_match);
                    end
                    // Last compare leaves the pipe when stage 2 is valid and stage 1 is empty.
                    if (r_v2 && !r_v1) begin
                        r_state   <= S_DONE;
                        r_busy    <= 1'b0;
                        r_q_done  <= 1'b1;
                        r_q_count <= r_acc + c_CNT_W'(r_match);
                        r_q_hit   <= (r_acc != '0) || r_match;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_CLEAR;
                end
            endcase
        end
    end

    assign busy    = r_busy;
    assign q_done  = r_q_done;
    assign q_hit   = r_q_hit;
    assign q_count = r_q_count;

endmodule
`default_nettype wire

// File: tb/tb_plot_shadow_fb.sv
`default_nettype none
// ============================================================================
//  Module   : tb_plot_shadow_fb
//  Purpose  : Self-checking bench for plot_shadow_fb: randomized plots and
//             queries against a behavioural framebuffer model, with a
//             scoreboard queue of expected query results.
//  Revision : 1.0  initial release
// ============================================================================
module tb_plot_shadow_fb;

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic [7:0] x = '0;
    logic [6:0] y = '0;
    logic [2:0] colour = '0;
    logic       plot = 1'b0;
    logic       busy;
    logic       q_start = 1'b0;
    logic [7:0] q_x = '0;
    logic [6:0] q_y = '0;
    logic [2:0] q_colour = '0;
    logic       q_done;
    logic       q_hit;
    logic [6:0] q_count;

    always #5 Clock = ~Clock;

    plot_shadow_fb dut (
        .Clock    (Clock),
        .Resetn   (Resetn),
        .x        (x),
        .y        (y),
        .colour   (colour),
        .plot     (plot),
        .busy     (busy),
        .q_start  (q_start),
        .q_x      (q_x),
        .q_y      (q_y),
        .q_colour (q_colour),
        .q_done   (q_done),
        .q_hit    (q_hit),
        .q_count  (q_count)
    );

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // ------------------------------------------------------------------
    // Reference model: screen array plus timing rules of the interface.
    // ------------------------------------------------------------------
    bit [2:0] fb [0:19199];
    bit       m_started = 1'b0;
    int       m_clr = 0;
    bit       m_q = 1'b0;
    bit       m_done = 1'b0;
    bit       m_was_done = 1'b0;
    int       m_k = 0;
    int       m_qx = 0, m_qy = 0, m_qc = 0;
    int       m_cnt = 0;
    int       m_held = 0;
    int       m_px = 0, m_py = 0, m_p = 0;
    int       exp_q [$];

    always @(posedge Clock) begin
        if (!Resetn) begin
            m_started = 1'b1;
            m_clr     = 19200;
            m_q       = 1'b0;
            m_done    = 1'b0;
            m_held    = 0;
            foreach (fb[i]) fb[i] = 3'b000;
        end else if (m_started) begin
            m_was_done = m_done;
            m_done     = 1'b0;
            if (m_clr > 0) begin
                m_clr--;
            end else begin
                if (m_q) begin
                    m_k++;
                    // Pixel p of the square is read on edge p+1 after acceptance.
                    if (m_k <= 100) begin
                        m_p  = m_k - 1;
                        m_px = m_qx + m_p % 10;
                        m_py = m_qy + m_p / 10;
                        if (m_px < 160 && m_py < 120 && int'(fb[m_py * 160 + m_px]) == m_qc)
                            m_cnt++;
                    end
                    if (m_k == 102) begin
                        m_q    = 1'b0;
                        m_done = 1'b1;
                        m_held = m_cnt;
                        exp_q.push_back(m_cnt);
                    end
                end else if (!m_was_done && q_start) begin
                    m_q    = 1'b1;
                    m_k    = 0;
                    m_qx   = int'(q_x);
                    m_qy   = int'(q_y);
                    m_qc   = int'(q_colour);
                    m_cnt  = 0;
                    m_held = 0;
                end
                // Writes land after the read of this edge (old data is read).
                if (plot && int'(x) < 160 && int'(y) < 120)
                    fb[int'(y) * 160 + int'(x)] = colour;
            end
        end
    end

    // ------------------------------------------------------------------
    // Monitor: per-cycle status checks and scoreboard pop on q_done.
    // ------------------------------------------------------------------
    int e_cnt;
    always @(negedge Clock) begin
        if (m_started) begin
            chk("busy", int'(busy), int'((m_clr > 0) || m_q));
            chk("q_done_timing", int'(q_done), int'(m_done));
            chk("q_count_hold", int'(q_count), m_held);
            chk("q_hit_hold", int'(q_hit), int'(m_held != 0));
            if (q_done === 1'b1) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_q_done", 1, 0);
                end else begin
                    e_cnt = exp_q.pop_front();
                    chk("q_count", int'(q_count), e_cnt);
                    chk("q_hit", int'(q_hit), int'(e_cnt != 0));
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------
    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic plot_px(input int px, input int py, input int c);
        x      = 8'(px);
        y      = 7'(py);
        colour = 3'(c);
        plot   = 1'b1;
        tick();
        plot   = 1'b0;
    endtask

    task automatic start_q(input int qx, input int qy, input int qc);
        q_x      = 8'(qx);
        q_y      = 7'(qy);
        q_colour = 3'(qc);
        q_start  = 1'b1;
        tick();
        q_start  = 1'b0;
    endtask

    task automatic rand_plot();
        x      = 8'($urandom_range(0, 175));
        y      = 7'($urandom_range(0, 127));
        colour = 3'($urandom_range(0, 7));
        plot   = ($urandom_range(0, 2) == 0);
    endtask

    task automatic wait_done(input bit rnd, input bit poke_done);
        int n = 0;
        while (q_done !== 1'b1 && n < 300) begin
            if (rnd) rand_plot();
            tick();
            n++;
        end
        plot = 1'b0;
        chk("done_timeout", int'(n < 300), 1);
        // A request raised in the DONE cycle must be ignored.
        if (poke_done) begin
            q_x = 8'd0; q_y = 7'd0; q_colour = 3'd0;
            q_start = 1'b1;
        end
        tick();
        q_start = 1'b0;
        tick();
    endtask

    task automatic run_query(input int qx, input int qy, input int qc);
        start_q(qx, qy, qc);
        wait_done(1'b0, 1'b0);
    endtask

    initial begin
        Resetn = 1'b0;
        tick();
        tick();
        Resetn = 1'b1;
        // Plots and requests during the clear sweep are dropped.
        plot_px(5, 5, 3);
        for (int i = 0; i < 19215; i++) begin
            if (i < 19190) begin
                rand_plot();
                q_x     = 8'($urandom_range(0, 159));
                q_start = ($urandom_range(0, 63) == 0);
            end else begin
                plot    = 1'b0;
                q_start = 1'b0;
            end
            tick();
        end
        plot    = 1'b0;
        q_start = 1'b0;

        plot_px(160, 5, 3);
        plot_px(5, 120, 3);
        run_query(0, 0, 3);
        run_query(0, 0, 0);

        for (int yy = 0; yy < 10; yy++)
            for (int xx = 0; xx < 10; xx++)
                plot_px(80 + xx, 60 + yy, 4);
        run_query(80, 60, 4);
        run_query(75, 55, 4);
        run_query(0, 0, 4);
        run_query(155, 115, 0);
        run_query(150, 110, 4);

        // Writes racing the scan, plus a request while busy.
        start_q(80, 60, 3);
        plot_px(85, 65, 3);
        q_x = 8'd0; q_y = 7'd0; q_colour = 3'd4;
        q_start = 1'b1;
        tick();
        q_start = 1'b0;
        repeat (15) tick();
        plot_px(80, 60, 3);
        wait_done(1'b0, 1'b0);
        run_query(80, 60, 3);

        for (int t = 0; t < 25; t++) begin
            for (int j = 0; j < int'($urandom_range(0, 20)); j++) begin
                rand_plot();
                tick();
            end
            plot = 1'b0;
            start_q($urandom_range(0, 170), $urandom_range(0, 127), $urandom_range(0, 7));
            wait_done(1'b1, ($urandom_range(0, 3) == 0));
        end

        // Reset in the middle of a query: no result, memory re-cleared.
        start_q(80, 60, 4);
        repeat (48) tick();
        Resetn = 1'b0;
        tick();
        Resetn = 1'b1;
        repeat (19205) tick();
        run_query(80, 60, 4);
        run_query(80, 60, 0);

        repeat (3) tick();
        chk("pending_results", exp_q.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/plot_shadow_fb.md
Name: plot_shadow_fb

Overview:
- Responder side of the pixel-plot interface (x, y, colour, plot) that the drawing FSMs drive toward the VGA adapter.
- Keeps a shadow copy of the 160x120 3-bit framebuffer, driven by the same write strobes as the adapter.
- Answers region queries: scans a QDIM x QDIM square and reports how many pixels match a given colour.
- The game logic uses it for snake/apple/self-collision checks without reading back the adapter.

Parameters:
- XSCREEN, 160, screen width in pixels.
- YSCREEN, 120, screen height in pixels.
- QDIM, 10, side length of the square query region (matches object size XDIM/YDIM).
- BG, 3'b000, colour written during the clear sweep.

Ports:
- Clock  in  1  system clock (CLOCK_50).
- Resetn  in  1  synchronous active-low reset, sampled on posedge Clock.
- x  in  8  plot column.
- y  in  7  plot row.
- colour  in  3  plot colour.
- plot  in  1  write strobe; one pixel per cycle while high.
- busy  out  1  high during the clear sweep and during a query.
- q_start  in  1  query request; sampled only in IDLE.
- q_x  in  8  query region left column.
- q_y  in  7  query region top row.
- q_colour  in  3  colour to match.
- q_done  out  1  one-cycle pulse when the query result is valid.
- q_hit  out  1  high when q_count is non-zero.
- q_count  out  7  number of matching in-screen pixels, 0..QDIM*QDIM.

Behaviour:
- Clock and reset:
  - Single clock. Reset is synchronous and active-low.
  - Resetn low forces state CLEAR with the clear address at 0, busy=1, q_done=0, q_hit=0, q_count=0.
- Storage:
  - XSCREEN*YSCREEN x 3-bit memory; address = y*XSCREEN + x, 15 bits.
  - One write port and one synchronous read port.
  - Read-before-write: reading an address in the same cycle it is written returns the old value.
- State CLEAR:
  - Writes BG to addresses 0..19199, one per cycle.
  - After writing 19199, moves to IDLE, so busy falls exactly 19200 cycles after the reset-release edge.
  - plot is ignored (dropped) throughout CLEAR.
- Write path (IDLE and QUERY):
  - When plot=1, x<XSCREEN and y<YSCREEN, colour is written on that edge.
  - Out-of-range coordinates are silently dropped.
  - Writes are never stalled.
- State IDLE:
  - q_start=1 latches q_x, q_y, q_colour, clears the count and enters QUERY.
  - busy rises the next cycle.
- State QUERY:
  - Column counter xc and row counter yc scan row-major from (0,0) to (QDIM-1,QDIM-1), one read per cycle.
  - Reads are issued for QDIM*QDIM cycles.
  - Each read has 1-cycle latency; a delayed in-range flag and a delayed compare accumulate into q_count.
  - Pixels with q_x+xc>=XSCREEN or q_y+yc>=YSCREEN are not counted. Do not wrap; do the sums at 9/8-bit width so they cannot overflow.
  - After the last compare, move to DONE.
- State DONE:
  - Lasts one cycle: q_done=1, then IDLE. busy is low in DONE.
  - q_done is high exactly QDIM*QDIM+2 cycles after the edge that sampled q_start.
- Output holding:
  - q_count and q_hit update on the q_done cycle.
  - They hold until the next accepted q_start, which clears them.
- Ignored and interacting requests:
  - q_start while busy is ignored; no queueing.
  - A write to a pixel before its scan position is reflected in the count; a write after its position is not.
- Reset mid-operation: any state returns to CLEAR, no q_done is issued and memory is re-cleared.

Test Plan:
- Reset pulse → busy=1 for exactly 19200 cycles. Then query (0,0) with colour 000 → q_done after 102 cycles, q_count=100, q_hit=1.
- Plot a 10x10 block of 3'b100 at (80,60) (100 writes) → query (80,60) colour 100 gives count 100; query (75,55) colour 100 gives count 25; query (0,0) colour 100 gives count 0, hit 0.
- After clear, query (155,115) colour 000 → count 25 (clipped at the screen edge), and no wrapped pixels at (0,0) are counted.
- Plot (5,5) colour 011 during CLEAR, and plot (160,5) and (5,120) colour 011 in IDLE → query (0,0) colour 011 gives count 0.
- Start query (80,60) colour 011:
  - write (85,65)=011 on the 2nd QUERY cycle → counted, count 1;
  - a second q_start mid-query → ignored, exactly one q_done;
  - write (80,60)=011 after its read → not counted.
- Drop Resetn for 1 cycle at QUERY cycle 50 → no q_done, busy=1 for 19200 cycles, q_count=0, earlier plotted pixels read back as BG.
